// File: rtl/wb_ram_burst.sv
// Wishbone B3 slave RAM: classic cycles plus CTI/BTE incrementing bursts (linear, wrap-4/8/16)
// with one beat per clock, byte-lane writes and out-of-range error termination.
module wb_ram_burst #(
    parameter int    dw      = 32,
    parameter int    aw      = 32,
    parameter int    DEPTH   = 256,
    parameter string MEMFILE = ""
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [aw-1:0]   wb_adr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [dw/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [dw-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = dw / 8;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    logic [dw-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [IW-1:0] adr_q, adr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [dw-1:0] dat_q, dat_d;

    logic          req;
    logic          in_range;
    logic          beat;
    logic          wr_en;
    logic          lin_ovf;
    logic          rd_en;
    logic [IW-1:0] req_idx;
    logic [IW-1:0] nxt_idx;
    logic [IW-1:0] rd_idx;
    logic [dw-1:0] rd_word;
    logic [dw-1:0] rd_fwd;
    logic          unused_adr_lo;

    // Wrap bursts only advance the low log2(N) bits; linear advances the whole index.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] a, input logic [1:0] bte);
        logic [IW-1:0] m;
        logic [IW-1:0] inc;
        inc = a + IW'(1);
        case (bte)
            2'b00:   m = '1;
            2'b01:   m = IW'(3);
            2'b10:   m = IW'(7);
            default: m = IW'(15);
        endcase
        return (a & ~m) | (inc & m);
    endfunction

    assign unused_adr_lo = ^wb_adr_i[1:0];

    assign req_idx  = wb_adr_i[IW+1:2];
    assign in_range = (wb_adr_i[aw-1:IW+2] == '0);
    // While an error is being signalled the master still holds stb; that is not a new request.
    assign req      = wb_cyc_i & wb_stb_i & ~err_q;
    assign beat     = ack_q & wb_cyc_i & wb_stb_i;
    assign wr_en    = beat & wb_we_i & ~wb_rst_i;
    assign nxt_idx  = next_idx(adr_q, wb_bte_i);
    assign lin_ovf  = (wb_bte_i == 2'b00) && (adr_q == '1);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = adr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        adr_d   = req_idx;
                        rd_idx  = req_idx;
                        rd_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = (wb_cti_i == CTI_INCR) ? BURST : CLASSIC;
                    end
                end
            end
            CLASSIC: begin
                state_d = IDLE;
            end
            BURST: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (beat) begin
                    if (wb_cti_i == CTI_EOB) begin
                        state_d = IDLE;
                    end else if (lin_ovf) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        adr_d  = nxt_idx;
                        rd_idx = nxt_idx;
                        rd_en  = 1'b1;
                        ack_d  = 1'b1;
                    end
                end else begin
                    // Master wait state: hold the beat address, re-ack once stb returns.
                    ack_d = wb_stb_i;
                    rd_en = wb_stb_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_word = mem[rd_idx];

    always_comb begin
        rd_fwd = rd_word;
        if (wr_en && (adr_q == rd_idx)) begin
            for (int k = 0; k < SW; k++) begin
                if (wb_sel_i[k]) begin
                    rd_fwd[8*k +: 8] = wb_dat_i[8*k +: 8];
                end
            end
        end
        dat_d = rd_en ? rd_fwd : dat_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < SW; k++) begin
                if (wb_sel_i[k]) begin
                    mem[adr_q][8*k +: 8] <= wb_dat_i[8*k +: 8];
                end
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = err_q & wb_cyc_i;
    assign wb_rty_o = 1'b0;

endmodule
